pic_int_sequencer: RTL and testbench

PIC_INT_SEQUENCER -- requirements
Module: pic_int_sequencer

---
 rtl/pic_pkg.sv | 19 +
 rtl/pic_priority_resolver.sv | 18 +
 rtl/pic_int_sequencer.sv | 157 +++++++++++++++
 tb/tb_pic_int_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM state encoding,
// interrupt level type and the spurious-vector level.
package pic_pkg;

  typedef logic [2:0] pic_lvl_t;

  typedef enum logic [1:0] {
    PIC_IDLE = 2'd0,
    PIC_ACK1 = 2'd1,
    PIC_ACK2 = 2'd2
  } pic_state_e;

  localparam pic_lvl_t SPURIOUS_LVL = 3'd7;

  function automatic logic [7:0] lvl_onehot(input pic_lvl_t lvl);
    return 8'b1 << lvl;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Fixed-priority encoder: reports the lowest-numbered set request (IR0 wins).
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] req_i,
  output logic       valid_o,
  output pic_lvl_t   lvl_o
);

  always_comb begin
    valid_o = |req_i;
    lvl_o   = SPURIOUS_LVL;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[i]) lvl_o = pic_lvl_t'(i);
    end
  end

endmodule

// File: rtl/pic_int_sequencer.sv
// 8259-style interrupt sequencer: request capture, fixed priority arbitration,
// two-pulse INTA handshake with vector output and in-service tracking.
//
// state    | meaning
// PIC_IDLE | waiting; raises int_o when a pending level beats in-service
// PIC_ACK1 | first INTA seen, winner latched, waiting for second INTA
// PIC_ACK2 | vector driven while INTA low, exits on INTA release
module pic_int_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ir,
  input  logic       inta_n,
  input  logic [7:0] imr,
  input  logic       ltim,
  input  logic       aeoi,
  input  logic [4:0] vec_base,
  input  logic       eoi,
  input  logic       seoi,
  input  logic [2:0] seoi_lvl,
  output logic       int_o,
  output logic [7:0] vec_data,
  output logic       vec_oe,
  output logic [7:0] irr,
  output logic [7:0] isr
);

  logic [SYNC_STAGES-1:0][7:0] ir_sync_q;
  logic [SYNC_STAGES-1:0]      inta_sync_q;
  logic [7:0]                  ir_last_q;
  logic                        inta_last_q;
  logic [1:0]                  blank_q;

  pic_state_e state_q, state_d;
  logic       int_q, int_d;
  pic_lvl_t   lvl_q, lvl_d;
  logic       spur_q, spur_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;

  logic [7:0] ir_s, ir_rise, pending;
  logic       inta_s, inta_fall, inta_rise;
  logic       pend_valid, isr_valid, req_ok;
  pic_lvl_t   pend_lvl, isr_lvl;
  logic [7:0] isr_set, irr_clr, eoi_clr, seoi_clr, aeoi_clr;

  assign ir_s      = ir_sync_q[SYNC_STAGES-1];
  assign inta_s    = inta_sync_q[SYNC_STAGES-1];
  assign inta_fall = inta_last_q & ~inta_s;
  assign inta_rise = ~inta_last_q & inta_s;
  // Edges are ignored until the synchronizers hold real pin values again, so a
  // pin held high across reset does not look like a fresh request.
  assign ir_rise   = (blank_q == 2'd0) ? (ir_s & ~ir_last_q) : 8'h00;

  assign irr     = ltim ? ir_s : irr_q;
  assign isr     = isr_q;
  assign pending = irr & ~imr;

  pic_priority_resolver u_pend_res (
    .req_i   (pending),
    .valid_o (pend_valid),
    .lvl_o   (pend_lvl)
  );

  pic_priority_resolver u_isr_res (
    .req_i   (isr_q),
    .valid_o (isr_valid),
    .lvl_o   (isr_lvl)
  );

  assign req_ok = pend_valid && (!isr_valid || (pend_lvl < isr_lvl));

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    lvl_d    = lvl_q;
    spur_d   = spur_q;
    isr_set  = 8'h00;
    irr_clr  = 8'h00;
    aeoi_clr = 8'h00;
    case (state_q)
      PIC_IDLE: begin
        if (inta_fall && int_q) begin
          state_d = PIC_ACK1;
          int_d   = 1'b0;
          if (pend_valid) begin
            lvl_d   = pend_lvl;
            spur_d  = 1'b0;
            isr_set = lvl_onehot(pend_lvl);
            irr_clr = lvl_onehot(pend_lvl);
          end else begin
            lvl_d  = SPURIOUS_LVL;
            spur_d = 1'b1;
          end
        end else begin
          int_d = int_q | req_ok;
        end
      end
      PIC_ACK1: begin
        if (inta_fall) state_d = PIC_ACK2;
      end
      PIC_ACK2: begin
        if (inta_rise) begin
          state_d = PIC_IDLE;
          if (aeoi && !spur_q) aeoi_clr = lvl_onehot(lvl_q);
        end
      end
      default: state_d = PIC_IDLE;
    endcase
  end

  // Clears are taken from the current isr, then the acknowledge set is applied.
  assign eoi_clr  = (eoi && isr_valid) ? lvl_onehot(isr_lvl) : 8'h00;
  assign seoi_clr = seoi ? lvl_onehot(seoi_lvl) : 8'h00;
  assign isr_d    = (isr_q & ~(eoi_clr | seoi_clr | aeoi_clr)) | isr_set;
  assign irr_d    = ltim ? 8'h00 : ((irr_q & ~irr_clr) | ir_rise);

  assign vec_oe   = (state_q == PIC_ACK2) && !inta_s;
  assign vec_data = vec_oe ? {vec_base, lvl_q} : 8'h00;
  assign int_o    = int_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_sync_q   <= '0;
      inta_sync_q <= '0;
      ir_last_q   <= 8'h00;
      inta_last_q <= 1'b0;
      blank_q     <= 2'(SYNC_STAGES);
      state_q     <= PIC_IDLE;
      int_q       <= 1'b0;
      lvl_q       <= 3'd0;
      spur_q      <= 1'b0;
      irr_q       <= 8'h00;
      isr_q       <= 8'h00;
    end else begin
      ir_sync_q   <= {ir_sync_q[SYNC_STAGES-2:0], ir};
      inta_sync_q <= {inta_sync_q[SYNC_STAGES-2:0], inta_n};
      inta_last_q <= inta_s;
      if (blank_q != 2'd0) begin
        blank_q   <= blank_q - 2'd1;
        ir_last_q <= 8'hFF;
      end else begin
        ir_last_q <= ir_s;
      end
      state_q <= state_d;
      int_q   <= int_d;
      lvl_q   <= lvl_d;
      spur_q  <= spur_d;
      irr_q   <= irr_d;
      isr_q   <= isr_d;
    end
  end

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Bench for pic_int_sequencer: directed scenarios plus randomized operations
// checked against a transaction-level model of the 8259 request/service rules.
module tb_pic_int_sequencer;

  localparam int SETTLE = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir;
  logic       inta_n;
  logic [7:0] imr;
  logic       ltim;
  logic       aeoi;
  logic [4:0] vec_base;
  logic       eoi;
  logic       seoi;
  logic [2:0] seoi_lvl;
  logic       int_o;
  logic [7:0] vec_data;
  logic       vec_oe;
  logic [7:0] irr;
  logic [7:0] isr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_irr, m_isr;
  logic       m_int;

  pic_int_sequencer #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ir       (ir),
    .inta_n   (inta_n),
    .imr      (imr),
    .ltim     (ltim),
    .aeoi     (aeoi),
    .vec_base (vec_base),
    .eoi      (eoi),
    .seoi     (seoi),
    .seoi_lvl (seoi_lvl),
    .int_o    (int_o),
    .vec_data (vec_data),
    .vec_oe   (vec_oe),
    .irr      (irr),
    .isr      (isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Highest-priority (lowest index) set bit, 8 when nothing is set.
  function automatic int hi(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function automatic logic want_int();
    logic [7:0] pend;
    pend = m_irr & ~imr;
    return (pend != 8'h00) && (hi(pend) < hi(m_isr));
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".int"}, {31'd0, int_o}, {31'd0, m_int});
    chk({tag, ".irr"}, {24'd0, irr}, {24'd0, m_irr});
    chk({tag, ".isr"}, {24'd0, isr}, {24'd0, m_isr});
  endtask

  task automatic pulse_ir(input logic [7:0] mask);
    ir = ir | mask;
    tick(SETTLE);
    ir = ir & ~mask;
    tick(SETTLE);
    m_irr = m_irr | mask;
    m_int = m_int | want_int();
  endtask

  task automatic do_eoi(input logic specific, input logic [2:0] lvl);
    if (specific) begin
      seoi = 1'b1; seoi_lvl = lvl;
    end else begin
      eoi = 1'b1;
    end
    tick(1);
    eoi = 1'b0; seoi = 1'b0;
    tick(SETTLE);
    if (specific) m_isr[lvl] = 1'b0;
    else if (m_isr != 8'h00) m_isr[hi(m_isr)] = 1'b0;
    m_int = m_int | want_int();
  endtask

  task automatic do_ack(input logic aeoi_v, input logic mask_mid, input string tag);
    logic       taken, spur;
    logic [2:0] lvl;
    logic [7:0] pend, imr_keep;
    aeoi  = aeoi_v;
    taken = m_int;
    spur  = 1'b0;
    lvl   = 3'd0;
    if (taken) begin
      pend = m_irr & ~imr;
      if (pend == 8'h00) begin
        spur = 1'b1; lvl = 3'd7;
      end else begin
        lvl = 3'(hi(pend));
        m_isr[lvl] = 1'b1;
        if (!ltim) m_irr[lvl] = 1'b0;
      end
      m_int = 1'b0;
    end
    inta_n = 1'b0;
    tick(SETTLE);
    chk({tag, ".ack1_int"}, {31'd0, int_o}, {31'd0, m_int});
    chk({tag, ".ack1_oe"}, {31'd0, vec_oe}, 32'd0);
    inta_n = 1'b1;
    tick(SETTLE);
    imr_keep = imr;
    if (mask_mid) imr = 8'hFF;
    inta_n = 1'b0;
    tick(SETTLE);
    chk({tag, ".vec_oe"}, {31'd0, vec_oe}, {31'd0, taken});
    chk({tag, ".vec"}, {24'd0, vec_data}, taken ? {24'd0, vec_base, lvl} : 32'd0);
    imr = imr_keep;
    inta_n = 1'b1;
    tick(SETTLE);
    chk({tag, ".oe_off"}, {31'd0, vec_oe}, 32'd0);
    if (taken && aeoi_v && !spur) m_isr[lvl] = 1'b0;
    m_int = m_int | want_int();
    aeoi = 1'b0;
  endtask

  task automatic model_reset();
    m_irr = 8'h00; m_isr = 8'h00; m_int = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ir = 8'h00; inta_n = 1'b1; imr = 8'h00; ltim = 1'b0;
    aeoi = 1'b0; vec_base = 5'b01000; eoi = 1'b0; seoi = 1'b0; seoi_lvl = 3'd0;
    model_reset();
    tick(3);
    chk("rst.int", {31'd0, int_o}, 32'd0);
    chk("rst.oe", {31'd0, vec_oe}, 32'd0);
    chk("rst.vec", {24'd0, vec_data}, 32'd0);
    chk("rst.irr", {24'd0, irr}, 32'd0);
    chk("rst.isr", {24'd0, isr}, 32'd0);
    rst_n = 1'b1;
    tick(SETTLE);
    check_regs("post_rst");

    // Basic acknowledge of IR3
    pulse_ir(8'h08);
    check_regs("ir3");
    do_ack(1'b0, 1'b0, "ack3");
    check_regs("ack3");
    do_eoi(1'b0, 3'd0);
    check_regs("eoi3");

    // Nesting: IR2 interrupts IR5 in service, re-edge on in-service IR5
    pulse_ir(8'h20);
    do_ack(1'b0, 1'b0, "ack5");
    pulse_ir(8'h04);
    check_regs("ir2_nest");
    do_ack(1'b0, 1'b0, "ack2");
    check_regs("ack2");
    pulse_ir(8'h20);
    check_regs("ir5_again");
    do_eoi(1'b0, 3'd0);
    check_regs("eoi_a");
    do_eoi(1'b0, 3'd0);
    check_regs("eoi_b");
    do_ack(1'b0, 1'b0, "ack5b");
    do_eoi(1'b1, 3'd5);
    check_regs("seoi5");

    // EOI / SEOI / AEOI
    pulse_ir(8'h10);
    do_ack(1'b0, 1'b0, "ack4");
    pulse_ir(8'h02);
    do_ack(1'b0, 1'b0, "ack1");
    check_regs("isr12");
    do_eoi(1'b0, 3'd0);
    check_regs("eoi12");
    do_eoi(1'b1, 3'd4);
    check_regs("seoi4");
    pulse_ir(8'h02);
    do_ack(1'b1, 1'b0, "aeoi1");
    check_regs("aeoi1");

    // Masked request, then unmask
    imr = 8'h10;
    pulse_ir(8'h10);
    check_regs("masked4");
    imr = 8'h00;
    tick(1);
    chk("unmask.int", {31'd0, int_o}, 32'd1);
    m_int = 1'b1;
    do_ack(1'b0, 1'b1, "ack4m");
    do_eoi(1'b0, 3'd0);
    check_regs("eoi4m");

    // Level mode, request withdrawn before acknowledge -> spurious
    ltim = 1'b1;
    ir = 8'h40;
    tick(SETTLE);
    m_irr = 8'h40;
    m_int = m_int | want_int();
    check_regs("lvl6");
    ir = 8'h00;
    tick(SETTLE);
    m_irr = 8'h00;
    check_regs("lvl6_drop");
    do_ack(1'b0, 1'b0, "spur");
    check_regs("spur");
    ltim = 1'b0;
    tick(SETTLE);

    // Reset during ACK1
    pulse_ir(8'h01);
    inta_n = 1'b0;
    tick(SETTLE);
    chk("ack1.int", {31'd0, int_o}, 32'd0);
    rst_n = 1'b0;
    tick(2);
    chk("mid_rst.int", {31'd0, int_o}, 32'd0);
    chk("mid_rst.oe", {31'd0, vec_oe}, 32'd0);
    chk("mid_rst.irr", {24'd0, irr}, 32'd0);
    chk("mid_rst.isr", {24'd0, isr}, 32'd0);
    inta_n = 1'b1;
    rst_n = 1'b1;
    model_reset();
    tick(SETTLE);
    check_regs("after_rst");
    inta_n = 1'b0; tick(SETTLE);
    chk("after_rst.oe", {31'd0, vec_oe}, 32'd0);
    inta_n = 1'b1; tick(SETTLE);

    // Pin held high across reset must not count as a request
    ir = 8'h02;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(SETTLE);
    check_regs("held_hi");
    ir = 8'h00;
    tick(SETTLE);
    pulse_ir(8'h02);
    check_regs("fresh_edge");
    do_ack(1'b1, 1'b0, "fresh_ack");

    // Randomized operations
    vec_base = 5'($urandom);
    for (int it = 0; it < 60; it++) begin
      int op;
      logic [7:0] m;
      op = $urandom_range(0, 4);
      case (op)
        0, 1: begin
          m = 8'($urandom & $urandom);
          if (m == 8'h00) m = 8'h01 << $urandom_range(0, 7);
          pulse_ir(m);
        end
        2: begin
          if (m_int) do_ack(1'($urandom), 1'($urandom), "r_ack");
          else pulse_ir(8'h01 << $urandom_range(0, 7));
        end
        3: do_eoi(1'($urandom), 3'($urandom));
        default: begin
          imr = 8'($urandom & $urandom & $urandom);
          tick(SETTLE);
          m_int = m_int | want_int();
        end
      endcase
      check_regs("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
